// File: rtl/hmmm_muldiv_if.sv
// Request/response bundle between the core controller and the iterative mul/div unit.
// The controller drives start/op/a/b and waits on ready/done; results are held by the unit.
interface hmmm_muldiv_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             divzero;

    modport master (
        output start, op, a, b,
        input  ready, done, result, overflow, divzero
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, result, overflow, divzero
    );
endinterface

// File: rtl/hmmm_muldiv.sv
// Iterative signed multiply/divide unit: operands are reduced to magnitudes, one
// shift-add or restoring-divide step runs per clock, and signs are re-applied at the end.
module hmmm_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic            ph1,
    input  logic            reset,
    hmmm_muldiv_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MOD  = 2'b10;
    localparam logic [1:0] OP_MULH = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 ovf_q, ovf_d;
    logic                 dzo_q, dzo_d;

    logic                 is_div_s;
    logic                 b_zero_s;
    logic                 calc_div_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_take_s;
    logic [WIDTH-1:0]     div_diff_s;
    logic                 neg_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;

    // Magnitude of a two's complement value; the most negative input maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = ~v + WIDTH'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    assign is_div_s   = (bus.op == OP_DIV) || (bus.op == OP_MOD);
    assign b_zero_s   = (bus.b == '0);
    assign calc_div_s = (op_q == OP_DIV) || (op_q == OP_MOD);

    // p_q holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_sum_s   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_take_s  = (div_shift_s >= {1'b0, opnd_q});
    assign div_diff_s  = WIDTH'(div_shift_s - {1'b0, opnd_q});

    assign neg_s  = sa_q ^ sb_q;
    assign prod_s = neg_s ? (~p_q + (2*WIDTH)'(1)) : p_q;
    assign quo_s  = neg_s ? (~p_q[WIDTH-1:0] + WIDTH'(1)) : p_q[WIDTH-1:0];
    assign rem_s  = sa_q ? (~p_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : p_q[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; divide by zero skips the iteration and only passes through FIXUP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_div_s && b_zero_s) begin
                        state_d = S_FIXUP;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIXUP: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dzo_d    = dzo_q;
        ready_d  = (state_d == S_IDLE);
        done_d   = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    sa_d  = bus.a[WIDTH-1];
                    sb_d  = bus.b[WIDTH-1];
                    dz_d  = is_div_s && b_zero_s;
                    cnt_d = '0;
                    if (is_div_s) begin
                        opnd_d = mag(bus.b);
                        p_d    = {{WIDTH{1'b0}}, mag(bus.a)};
                    end else begin
                        opnd_d = mag(bus.a);
                        p_d    = {{WIDTH{1'b0}}, mag(bus.b)};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (calc_div_s) begin
                    if (div_take_s) begin
                        p_d = {div_diff_s, p_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = {div_shift_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    p_d = {mul_sum_s, p_q[WIDTH-1:1]};
                end
            end
            S_FIXUP: begin
                ovf_d = 1'b0;
                dzo_d = 1'b0;
                if (dz_q) begin
                    result_d = '0;
                    dzo_d    = 1'b1;
                end else begin
                    case (op_q)
                        OP_MUL: begin
                            result_d = prod_s[WIDTH-1:0];
                            ovf_d    = (prod_s[2*WIDTH-1:WIDTH-1] != '0) &&
                                       (prod_s[2*WIDTH-1:WIDTH-1] != '1);
                        end
                        OP_MULH: result_d = prod_s[2*WIDTH-1:WIDTH];
                        OP_DIV: begin
                            // Only -2^(WIDTH-1) / -1 yields a positive quotient with the top bit set.
                            result_d = quo_s;
                            ovf_d    = !neg_s && p_q[WIDTH-1];
                        end
                        OP_MOD:  result_d = rem_s;
                        default: result_d = '0;
                    endcase
                end
            end
            S_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Operand, accumulator and output registers.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            op_q     <= 2'b00;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dzo_q    <= dzo_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign bus.divzero  = dzo_q;
endmodule
